// File: rtl/bcd_to_binary.sv
// Serial packed-BCD to binary converter (reverse double-dabble, one bit per clock).
// Define BCD2BIN_INVALID_CHECK_EN to flag operands containing a nibble above 9.
module bcd_to_binary #(
    parameter int DIGITS = 9,
    parameter int BIN_W  = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t             state;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   bin_next;

    // Halving a BCD digit that received a carry-in of 10 leaves 8..12; subtract 3 to renormalise.
    function automatic logic [BCD_W-1:0] adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd8)
                r[4*i +: 4] = v[4*i +: 4] - 4'd3;
        end
        return r;
    endfunction

`ifdef BCD2BIN_INVALID_CHECK_EN
    function automatic logic has_invalid(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9)
                bad = 1'b1;
        end
        return bad;
    endfunction

    logic inv_reg;
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        bin_next = {bcd_reg[0], bin_reg[BIN_W-1:1]};
        bcd_next = adjust({1'b0, bcd_reg[BCD_W-1:1]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
`ifdef BCD2BIN_INVALID_CHECK_EN
            inv_reg <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bcd_reg <= bcd_in;
                        bin_reg <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
`ifdef BCD2BIN_INVALID_CHECK_EN
                        inv_reg <= has_invalid(bcd_in);
`endif
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        state <= FINISH;
                    end else begin
                        bcd_reg <= bcd_next;
                        bin_reg <= bin_next;
                        cnt     <= cnt + 1'b1;
                    end
                end
                FINISH: begin
`ifdef BCD2BIN_INVALID_CHECK_EN
                    bin_out <= inv_reg ? '0 : bin_reg;
                    err_q   <= inv_reg;
`else
                    bin_out <= bin_reg;
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed testbench for bcd_to_binary (DIGITS=9, BIN_W=30).
// Done is expected BIN_W+2 edges after the accepting edge.
module tb_bcd_to_binary;

    localparam int DIGITS = 9;
    localparam int BIN_W  = 30;
    localparam int LAT    = BIN_W + 2;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [4*DIGITS-1:0] bcd_in;
    logic                busy;
    logic                done;
    logic [BIN_W-1:0]    bin_out;
    logic                err;

    int nvec;
    int nerr;

    bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .bin_out(bin_out),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller invokes this away from a rising edge; returns edges to done (-1 on timeout).
    task automatic run_conv(input logic [4*DIGITS-1:0] v, output int lat,
                            output logic [BIN_W-1:0] res, output logic e);
        bcd_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        res = bin_out;
        e   = err;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (busy !== 1'b0) begin
            nerr++; $display("FAIL reset_busy got %b want 0", busy);
        end
        nvec++;
        if (done !== 1'b0) begin
            nerr++; $display("FAIL reset_done got %b want 0", done);
        end
        nvec++;
        if (bin_out !== '0) begin
            nerr++; $display("FAIL reset_bin got %h want 0", bin_out);
        end
        nvec++;
        if (err !== 1'b0) begin
            nerr++; $display("FAIL reset_err got %b want 0", err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        int lat;
        logic [BIN_W-1:0] r;
        logic e;
        @(negedge clk);
        run_conv('0, lat, r, e);
        nvec++;
        if (lat !== LAT) begin
            nerr++; $display("FAIL zero_latency got %0d want %0d", lat, LAT);
        end
        nvec++;
        if (r !== '0) begin
            nerr++; $display("FAIL zero_value got %h want 0", r);
        end
        nvec++;
        if (e !== 1'b0) begin
            nerr++; $display("FAIL zero_err got %b want 0", e);
        end
        @(posedge clk);
        #1;
        nvec++;
        if (done !== 1'b0) begin
            nerr++; $display("FAIL done_width got %b want 0", done);
        end
    endtask

    task automatic test_max();
        int lat;
        logic [BIN_W-1:0] r;
        logic e;
        @(negedge clk);
        run_conv(36'h999999999, lat, r, e);
        nvec++;
        if (lat !== LAT) begin
            nerr++; $display("FAIL max_latency got %0d want %0d", lat, LAT);
        end
        nvec++;
        if (r !== 30'h3B9AC9FF) begin
            nerr++; $display("FAIL max_value got %h want 3b9ac9ff", r);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [BIN_W-1:0] r;
        logic e;
        @(negedge clk);
        run_conv(36'h000012345, lat, r, e);
        nvec++;
        if (r !== 30'h3039) begin
            nerr++; $display("FAIL b2b_first got %h want 3039", r);
        end
        // Still inside the done cycle: issue the next request now.
        bcd_in = 36'h000000255;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 36'h000000999;
        nvec++;
        if (busy !== 1'b1) begin
            nerr++; $display("FAIL b2b_accept busy got %b want 1", busy);
        end
        nvec++;
        if (bin_out !== 30'h3039) begin
            nerr++; $display("FAIL b2b_hold got %h want 3039", bin_out);
        end
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            if (i == 5) start = 1'b1;
            if (i == 6) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        nvec++;
        if (lat !== LAT) begin
            nerr++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT);
        end
        nvec++;
        if (bin_out !== 30'hFF) begin
            nerr++; $display("FAIL b2b_second got %h want ff", bin_out);
        end
    endtask

    task automatic test_start_held();
        int nb;
        @(negedge clk);
        bcd_in = 36'h000000042;
        start  = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            nb = 0;
            while (!done && nb < 100) begin
                if (busy) nb++;
                @(posedge clk);
                #1;
            end
            nvec++;
            if (nb !== LAT) begin
                nerr++; $display("FAIL held_busy%0d got %0d want %0d", k, nb, LAT);
            end
            nvec++;
            if (bin_out !== 30'd42) begin
                nerr++; $display("FAIL held_value%0d got %0d want 42", k, bin_out);
            end
            if (k == 0) begin
                @(posedge clk);
                #1;
                nvec++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    nerr++; $display("FAIL held_reaccept busy %b done %b want 1 0", busy, done);
                end
            end
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (busy !== 1'b0) begin
            nerr++; $display("FAIL held_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic [BIN_W-1:0] r;
        logic e;
        @(negedge clk);
        bcd_in = 36'h000012345;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (busy !== 1'b0 || bin_out !== '0) begin
            nerr++; $display("FAIL mid_reset busy %b bin %h want 0 0", busy, bin_out);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        nvec++;
        if (seen !== 0) begin
            nerr++; $display("FAIL mid_reset_done got %0d pulses want 0", seen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_conv(36'h000098765, lat, r, e);
        nvec++;
        if (lat !== LAT || r !== 30'd98765) begin
            nerr++; $display("FAIL post_reset got lat %0d val %0d want %0d 98765", lat, r, LAT);
        end
    endtask

    task automatic test_invalid();
        int lat;
        logic [BIN_W-1:0] r;
        logic e;
        @(negedge clk);
        run_conv(36'h00000000A, lat, r, e);
        nvec++;
        if (lat !== LAT) begin
            nerr++; $display("FAIL inv_latency got %0d want %0d", lat, LAT);
        end
`ifdef BCD2BIN_INVALID_CHECK_EN
        nvec++;
        if (e !== 1'b1 || r !== '0) begin
            nerr++; $display("FAIL inv_flag got err %b bin %h want 1 0", e, r);
        end
`else
        nvec++;
        if (e !== 1'b0) begin
            nerr++; $display("FAIL inv_err got %b want 0", e);
        end
`endif
        @(negedge clk);
        run_conv(36'h000000007, lat, r, e);
        nvec++;
        if (e !== 1'b0 || r !== 30'd7) begin
            nerr++; $display("FAIL inv_recover got err %b bin %0d want 0 7", e, r);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_zero();
        test_max();
        test_back_to_back();
        test_start_held();
        test_reset_mid();
        test_invalid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 SHALL have parameter DIGITS, default 9, meaning the number of packed BCD input digits.
REQ-002 SHALL have parameter BIN_W, default 30, meaning the binary result width; 10^DIGITS-1 < 2^BIN_W is required.
REQ-003 SHALL have port clk  input  1  meaning the single rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  meaning the asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  meaning a conversion request, sampled on clk.
REQ-006 SHALL have port bcd_in  input  4*DIGITS  meaning packed BCD operand, most significant digit in the top nibble.
REQ-007 SHALL have port busy  output  1  meaning a conversion is in progress.
REQ-008 SHALL have port done  output  1  meaning a one-cycle pulse marking bin_out valid.
REQ-009 SHALL have port bin_out  output  BIN_W  meaning the registered binary result.
REQ-010 SHALL have port err  output  1  meaning an invalid BCD digit was seen (feature-dependent, see Configuration).

Function
REQ-011 SHALL implement a state machine with states IDLE, SHIFT and FINISH.
REQ-012 SHALL accept start only in IDLE; at that edge it SHALL load bcd_in into the BCD register, clear the binary shift register and counter, set busy, and go to SHIFT.
REQ-013 SHALL ignore start while in SHIFT or FINISH, with no effect on the current conversion.
REQ-014 SHALL, on each SHIFT edge, shift {bcd_reg, bin_reg} right by 1, then subtract 3 from every BCD nibble whose value is >= 8.
REQ-015 SHALL perform exactly BIN_W shifts, then go to FINISH.
REQ-016 SHALL, on the FINISH edge, load bin_reg into bin_out, pulse done high for exactly one cycle, clear busy, and return to IDLE.
REQ-017 SHALL place done BIN_W+2 cycles after the accepting start edge.
REQ-018 SHALL accept a start asserted during the done cycle, because the block is already in IDLE then.
REQ-019 SHALL hold bin_out and err stable from done until the next done; bcd_in changes after acceptance SHALL have no effect.
REQ-020 SHALL produce bin_out 0 for an all-zero operand; values up to 10^DIGITS-1 SHALL convert exactly, with no wrap.

Reset
REQ-021 SHALL, when rst_n is low, immediately and asynchronously force IDLE, busy=0, done=0, bin_out=0, err=0, and clear all shift registers and the counter.
REQ-022 SHALL abort any conversion in progress when reset is asserted mid-operation, with no done pulse.
REQ-023 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with macro BCD2BIN_INVALID_CHECK_EN defined, check every nibble of bcd_in at acceptance; if any nibble is > 9, err SHALL be 1 and bin_out SHALL be 0 at done, with the same latency as a valid conversion.
REQ-025 SHALL, with BCD2BIN_INVALID_CHECK_EN undefined, perform no check: err SHALL be tied to 0, and invalid nibbles SHALL pass through the same algorithm (result unspecified but deterministic).

Verification
REQ-026 SHALL cover a zero operand: bcd_in=0, start pulse -> done at cycle BIN_W+2, bin_out=0, err=0.
REQ-027 SHALL cover the maximum operand: bcd_in=0x999999999 -> bin_out=0x3B9AC9FF (999999999).
REQ-028 SHALL cover back-to-back conversions: bcd_in=0x000012345, then start again during the done cycle with 0x000000255 -> bin_out=0x3039, then bin_out=0xFF; the second done arrives BIN_W+2 cycles after the second start.
REQ-029 SHALL cover a start held high throughout a conversion -> only one conversion per IDLE entry; busy stays high for BIN_W+2 cycles per conversion.
REQ-030 SHALL cover reset mid-operation: rst_n low at shift 10 -> busy=0 and bin_out=0 immediately; no done pulse; the next start converts correctly.
REQ-031 SHALL cover an invalid digit with the macro defined: bcd_in=0x00000000A -> done with err=1 and bin_out=0; with the macro undefined, err=0.
